sensor_alarm_array: RTL and testbench

- Parametrised N-channel sensor-to-buzzer alarm controller; next generation of the 8-sensor/8-buzzer top-level state machine.
- Each channel owns an independent FSM:
  - debounces its sensor input;
  - drives a square-wave tone on its buzzer while alarmed;
  - optionally keeps sounding for a hold time, or latches until acknowledged.
- Sits between the ui_in sensor pins and the uo_out buzzer pins.
- Also exports aggregate status (any alarm, active count) for uio_out.

---
 rtl/sensor_alarm_array.sv | 99 +++++++++
 tb/tb_sensor_alarm_array.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sensor_alarm_array.sv
// sensor_alarm_array: N independent debounced sensor-to-buzzer alarm channels with aggregate status
module sensor_alarm_array #(
  parameter int NUM_CH       = 8,
  parameter int DEBOUNCE_CYC = 3,
  parameter int TONE_DIV     = 2,
  parameter int HOLD_CYC     = 4,
  parameter int LATCH        = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           sensor_i,
  input  logic [NUM_CH-1:0]           enable_i,
  input  logic [NUM_CH-1:0]           ack_i,
  output logic [NUM_CH-1:0]           buzz_o,
  output logic [NUM_CH-1:0]           active_o,
  output logic                        any_alarm_o,
  output logic [$clog2(NUM_CH+1)-1:0] alarm_count_o
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2(TONE_DIV + 1);
  localparam int HW = HOLD_CYC > 0 ? $clog2(HOLD_CYC + 1) : 1;
  localparam int CW = $clog2(NUM_CH + 1);
  typedef enum logic [1:0] {IDLE, ARM, ALARM, HOLD} state_t;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t        st;
    logic [DW-1:0] deb;
    logic [TW-1:0] tone;
    logic [HW-1:0] hc;
    logic          buzz, act;
    logic          wrap;
    assign wrap = tone == TW'(TONE_DIV - 1);
    always_ff @(posedge clk) begin
      if (rst || !enable_i[c]) begin
        st   <= IDLE;
        deb  <= '0;
        tone <= '0;
        hc   <= '0;
        buzz <= 1'b0;
        act  <= 1'b0;
      end else begin
        case (st)
          IDLE, ARM: begin
            if (!sensor_i[c]) begin
              st  <= IDLE;
              deb <= '0;
            end else if (DEBOUNCE_CYC == 1 || (st == ARM && deb == DW'(DEBOUNCE_CYC - 1))) begin
              st   <= ALARM;
              deb  <= '0;
              tone <= '0;
              buzz <= 1'b1;
              act  <= 1'b1;
            end else begin
              st  <= ARM;
              deb <= st == IDLE ? DW'(1) : deb + DW'(1);
            end
          end
          ALARM: begin
            tone <= wrap ? '0 : tone + TW'(1);
            buzz <= wrap ? ~buzz : buzz;
            // latched alarms clear only on an ack once the sensor has gone quiet
            if (LATCH != 0 ? (ack_i[c] && !sensor_i[c]) : (!sensor_i[c] && HOLD_CYC == 0)) begin
              st   <= IDLE;
              tone <= '0;
              buzz <= 1'b0;
              act  <= 1'b0;
            end else if (LATCH == 0 && !sensor_i[c]) begin
              st <= HOLD;
              hc <= '0;
            end
          end
          HOLD: begin
            tone <= wrap ? '0 : tone + TW'(1);
            buzz <= wrap ? ~buzz : buzz;
            if (sensor_i[c]) begin
              st <= ALARM;
              hc <= '0;
            end else if (hc == HW'(HOLD_CYC - 1)) begin
              st   <= IDLE;
              hc   <= '0;
              tone <= '0;
              buzz <= 1'b0;
              act  <= 1'b0;
            end else begin
              hc <= hc + HW'(1);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
    assign buzz_o[c]   = buzz;
    assign active_o[c] = act;
  end
  assign any_alarm_o = |active_o;
  always_comb begin
    alarm_count_o = '0;
    for (int i = 0; i < NUM_CH; i++) alarm_count_o = alarm_count_o + CW'(active_o[i]);
  end
endmodule

// File: tb/tb_sensor_alarm_array.sv
// tb_sensor_alarm_array: directed and random checks of two alarm arrays (hold and latch variants) against a cycle model
module tb_sensor_alarm_array;
  localparam int N = 8, DEB = 3, TD = 2, HC = 4;
  logic clk = 1'b0, rst;
  logic [N-1:0] sensor, en, ack;
  logic [N-1:0] buzz0, act0, buzz1, act1;
  logic any0, any1;
  logic [3:0] cnt0, cnt1;
  int n_chk = 0, n_fail = 0;
  int run[2][N], ph[2][N], lowc[2][N];
  bit alm[2][N], hld[2][N];

  sensor_alarm_array #(.NUM_CH(N), .DEBOUNCE_CYC(DEB), .TONE_DIV(TD), .HOLD_CYC(HC), .LATCH(0)) u_dut (
    .clk(clk), .rst(rst), .sensor_i(sensor), .enable_i(en), .ack_i(ack),
    .buzz_o(buzz0), .active_o(act0), .any_alarm_o(any0), .alarm_count_o(cnt0));
  sensor_alarm_array #(.NUM_CH(N), .DEBOUNCE_CYC(DEB), .TONE_DIV(TD), .HOLD_CYC(HC), .LATCH(1)) u_lat (
    .clk(clk), .rst(rst), .sensor_i(sensor), .enable_i(en), .ack_i(ack),
    .buzz_o(buzz1), .active_o(act1), .any_alarm_o(any1), .alarm_count_o(cnt1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // v=0 models the hold variant, v=1 the latching variant; tone phase is cycles since alarm entry
  task automatic model_step(input int v);
    for (int c = 0; c < N; c++) begin
      if (rst || !en[c]) begin
        alm[v][c] = 0; hld[v][c] = 0; run[v][c] = 0;
      end else if (!alm[v][c]) begin
        run[v][c] = sensor[c] ? run[v][c] + 1 : 0;
        if (run[v][c] >= DEB) begin
          alm[v][c] = 1; hld[v][c] = 0; ph[v][c] = 0; run[v][c] = 0;
        end
      end else begin
        ph[v][c]++;
        if (v == 1) begin
          if (ack[c] && !sensor[c]) alm[v][c] = 0;
        end else if (sensor[c]) hld[v][c] = 0;
        else if (!hld[v][c]) begin
          hld[v][c] = 1; lowc[v][c] = 0;
        end else begin
          lowc[v][c]++;
          if (lowc[v][c] == HC) begin alm[v][c] = 0; hld[v][c] = 0; end
        end
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] ea[2], eb[2];
    int cntv[2];
    @(posedge clk);
    #1;
    for (int v = 0; v < 2; v++) begin
      model_step(v);
      cntv[v] = 0;
      for (int c = 0; c < N; c++) begin
        ea[v][c] = alm[v][c];
        eb[v][c] = alm[v][c] && ((ph[v][c] / TD) % 2 == 0);
        cntv[v] += alm[v][c];
      end
    end
    chk("active_hold", act0, ea[0]);
    chk("buzz_hold", buzz0, eb[0]);
    chk("any_hold", any0, ea[0] != 0);
    chk("count_hold", cnt0, cntv[0]);
    chk("active_latch", act1, ea[1]);
    chk("buzz_latch", buzz1, eb[1]);
    chk("any_latch", any1, ea[1] != 0);
    chk("count_latch", cnt1, cntv[1]);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    rst = 1; en = '1; sensor = '0; ack = '0;
    ticks(2);
    chk("reset_active", act0, 0);
    chk("reset_buzz", buzz0, 0);
    chk("reset_count", cnt0, 0);
    rst = 0; sensor = 8'h01;
    ticks(2);
    sensor = 8'h00;
    tick();
    chk("glitch_rejected", act0, 0);
    sensor = 8'h01;
    ticks(3);
    chk("ch0_alarm_3rd_edge", act0[0], 1);
    chk("ch0_buzz_start_high", buzz0[0], 1);
    ticks(6);
    sensor = 8'h00;
    ticks(4);
    chk("ch0_hold_active", act0[0], 1);
    tick();
    chk("ch0_hold_expired", act0, 0);
    sensor = 8'h02;
    ticks(5);
    sensor = 8'h00;
    ticks(2);
    chk("ch1_in_hold", act0[1], 1);
    sensor = 8'h02;
    ticks(4);
    sensor = 8'h00;
    ticks(6);
    sensor = 8'h06;
    ticks(3);
    chk("pair_active", act0, 8'h06);
    chk("pair_any", any0, 1);
    chk("pair_count", cnt0, 2);
    en = 8'hFB;
    tick();
    chk("disable_buzz", buzz0[2], 0);
    chk("disable_count", cnt0, 1);
    en = 8'hFF; sensor = 8'h00;
    ticks(6);
    sensor = 8'h04;
    ticks(3);
    sensor = 8'h00;
    ticks(3);
    chk("latch_holds", act1[2], 1);
    sensor = 8'h04; ack = 8'h04;
    tick();
    chk("latch_ack_ignored", act1[2], 1);
    sensor = 8'h00; ack = 8'hFF;
    tick();
    chk("latch_ack_clears", act1[2], 0);
    ack = 8'h00; sensor = 8'hFF;
    ticks(5);
    rst = 1;
    tick();
    chk("rst_mid_active", act0, 0);
    chk("rst_mid_buzz", buzz0, 0);
    chk("rst_mid_latch", act1, 0);
    chk("rst_mid_any", any1, 0);
    rst = 0;
    ticks(2);
    chk("rst_redebounce", act0, 0);
    tick();
    chk("rst_realarm", act0, 8'hFF);
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(5) == 0) sensor[c] = ~sensor[c];
        en[c] = $urandom_range(19) != 0;
        ack[c] = $urandom_range(3) == 0;
      end
      rst = $urandom_range(99) == 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
